// File: rtl/uart_rx_if.sv
// UART receiver bus interface.
// Groups the oversample strobe, the serial line and the received-byte outputs.
//   os_stb   : 16x baud oversample tick, one clk wide
//   rxd      : asynchronous serial line, idle high
//   dout     : last received data byte
//   dout_vld : one-clk pulse, byte complete
//   perr     : parity error for the byte flagged by dout_vld
//   ferr     : framing error (stop bit low) for the byte flagged by dout_vld
// Modports: slave = the receiver, master = whoever drives the line and consumes bytes.
interface uart_rx_if;
    logic       os_stb;
    logic       rxd;
    logic [7:0] dout;
    logic       dout_vld;
    logic       perr;
    logic       ferr;

    modport slave (
        input  os_stb,
        input  rxd,
        output dout,
        output dout_vld,
        output perr,
        output ferr
    );

    modport master (
        output os_stb,
        output rxd,
        input  dout,
        input  dout_vld,
        input  perr,
        input  ferr
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, 8 data bits LSB first, optional even parity, one stop bit.
// Parameters:
//   PARITY_EN : 0 = no parity bit, nonzero = one even-parity bit after the data bits
// Ports:
//   clk  : single clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : uart_rx_if slave modport (os_stb, rxd in; dout, dout_vld, perr, ferr out)
module uart_rx #(
    parameter int unsigned PARITY_EN = 0
) (
    input logic     clk,
    input logic     rstn,
    uart_rx_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e     state_q, state_d;
    logic       rxd_meta_q, rxd_s;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] data_q, data_d;
    logic       perr_next_q, perr_next_d;
    // Set after a low stop bit; blocks start detection until the line is seen high.
    logic       wait_high_q, wait_high_d;
    logic [7:0] dout_q, dout_d;
    logic       vld_q, vld_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    // Two-flop synchronizer, resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_meta_q <= 1'b1;
            rxd_s      <= 1'b1;
        end else begin
            rxd_meta_q <= bus.rxd;
            rxd_s      <= rxd_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            tick_q      <= 4'd0;
            bit_q       <= 3'd0;
            data_q      <= 8'h00;
            perr_next_q <= 1'b0;
            wait_high_q <= 1'b0;
            dout_q      <= 8'h00;
            vld_q       <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            perr_next_q <= perr_next_d;
            wait_high_q <= wait_high_d;
            dout_q      <= dout_d;
            vld_q       <= vld_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        data_d      = data_q;
        perr_next_d = perr_next_q;
        wait_high_d = wait_high_q;
        dout_d      = dout_q;
        vld_d       = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        if (bus.os_stb) begin
            unique case (state_q)
                StIdle: begin
                    if (wait_high_q) begin
                        if (rxd_s) begin
                            wait_high_d = 1'b0;
                        end
                    end else if (!rxd_s) begin
                        state_d = StStart;
                        tick_d  = 4'd0;
                    end
                end

                StStart: begin
                    if (tick_q == 4'd7) begin
                        if (!rxd_s) begin
                            state_d     = StData;
                            tick_d      = 4'd0;
                            bit_d       = 3'd0;
                            perr_next_d = 1'b0;
                        end else begin
                            // Start bit gone high by mid-bit: treat as a glitch.
                            state_d = StIdle;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end

                StData: begin
                    // Counter wraps 15 -> 0, so each bit is sampled 16 ticks after the last.
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        data_d[bit_q] = rxd_s;
                        bit_d         = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = (PARITY_EN != 0) ? StParity : StStop;
                        end
                    end
                end

                StParity: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        perr_next_d = rxd_s ^ (^data_q);
                        state_d     = StStop;
                    end
                end

                StStop: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        state_d     = StIdle;
                        vld_d       = 1'b1;
                        dout_d      = data_q;
                        ferr_d      = ~rxd_s;
                        perr_d      = (PARITY_EN != 0) ? perr_next_q : 1'b0;
                        wait_high_d = ~rxd_s;
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = vld_q;
    assign bus.perr     = perr_q;
    assign bus.ferr     = ferr_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter PARITY_EN, default 0; 0 = frame with no parity bit, nonzero = one even-parity bit after the data bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops on rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port os_stb, input, 1 bit: one-clk-wide strobe at 16x baud rate (oversample tick).
REQ-005 The block SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port dout, output, 8 bits: last received data byte.
REQ-007 The block SHALL have port dout_vld, output, 1 bit: one-clk pulse, byte complete.
REQ-008 The block SHALL have port perr, output, 1 bit: parity error flag for the byte flagged by dout_vld.
REQ-009 The block SHALL have port ferr, output, 1 bit: framing error (stop bit sampled low) for the byte flagged by dout_vld.

Function
REQ-010 rxd SHALL pass through a 2-flop synchronizer, reset value 1; all logic below SHALL use the synchronized value rxd_s.
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; a 4-bit tick counter and a 3-bit bit counter SHALL advance only on os_stb.
REQ-012 IDLE: on os_stb with rxd_s == 0, the FSM SHALL go to START and clear the tick counter.
REQ-013 START: at tick count 7 (mid-bit), rxd_s == 0 SHALL go to DATA with both counters cleared; rxd_s == 1 SHALL return to IDLE (glitch rejection) with no output change.
REQ-014 DATA: every 16 os_stb ticks (tick count 15) the FSM SHALL sample rxd_s into bit position [bit counter], LSB first; after bit 7, go to PARITY if PARITY_EN else STOP.
REQ-015 PARITY: at tick 15 the FSM SHALL sample the parity bit; perr_next = sampled bit XOR (^data); go to STOP.
REQ-016 STOP: at tick 15 the FSM SHALL sample the stop bit, return to IDLE, and in the following clk assert dout_vld=1 for exactly one clk, load dout with the byte, and set ferr = ~stop_bit and perr = perr_next (perr = 0 when PARITY_EN == 0).
REQ-017 dout, perr, ferr SHALL hold their values until the next dout_vld; the byte SHALL be delivered even when ferr or perr is 1.
REQ-018 If ferr = 1 (line low at stop), the FSM SHALL remain in IDLE until rxd_s is sampled high on an os_stb before accepting a new start (no start detection on a held-low line).
REQ-019 Between os_stb pulses, the FSM and counters SHALL hold; os_stb held high continuously SHALL advance one tick per clk.
REQ-020 The shift/data register SHALL not change dout until dout_vld; a partially received byte SHALL never appear on dout.

Reset
REQ-021 While rstn = 0: FSM = IDLE, counters = 0, synchronizer = 1, dout = 0x00, dout_vld = 0, perr = 0, ferr = 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no dout_vld pulse; after release, the block SHALL wait for a new falling edge in IDLE.

Verification
REQ-023 PARITY_EN = 0, frame 0x55 with good stop bit, os_stb every 4 clk -> one dout_vld pulse, dout = 0x55, perr = 0, ferr = 0.
REQ-024 PARITY_EN = 1, byte 0xA7 with parity bit 1 (correct even) -> dout = 0xA7, perr = 0; same byte with parity bit 0 -> dout = 0xA7, perr = 1.
REQ-025 Stop bit driven 0 for byte 0x3C -> dout = 0x3C, ferr = 1; line held low 40 bit times -> no further dout_vld until line goes high and a new frame arrives.
REQ-026 rxd low pulse of 5 os_stb ticks in IDLE -> no dout_vld, FSM back in IDLE; next valid frame 0x81 -> dout = 0x81.
REQ-027 rstn pulsed low during data bit 4 of frame 0xFF -> no dout_vld, all outputs 0; next frame 0x12 -> dout = 0x12.
REQ-028 Back-to-back frames 0x00, 0xFF with a single stop bit each, looped from uart_tx -> two dout_vld pulses, values in order, no errors.
